// File: rtl/chipset_pkg.sv
// rtl/chipset_pkg.sv - shared types and helpers for the chipset data bus.
package chipset_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } router_state_e;

  localparam int DEFAULT_IDLE_VALUE = 0;

  // Room for every source index plus one extra code for "external or none".
  function automatic int idx_width(input int num_sources);
    return $clog2(num_sources + 1);
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - lowest-set-index encoder with valid and multi-hit flags.
module priority_encoder
  import chipset_pkg::*;
#(
  parameter int NUM_SOURCES = 4
) (
  input  logic [NUM_SOURCES-1:0]                req,
  output logic [idx_width(NUM_SOURCES)-1:0]     idx,
  output logic                                  valid,
  output logic                                  multi
);

  localparam int IDX_W = idx_width(NUM_SOURCES);

  always_comb begin
    idx = IDX_W'(NUM_SOURCES);
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign valid = |req;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(req & (req - NUM_SOURCES'(1)));

endmodule

// File: rtl/data_bus_router.sv
// rtl/data_bus_router.sv - registered, prioritised read-data router with wait states and contention tracking.
module data_bus_router
  import chipset_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    NUM_SOURCES = 4,
  parameter int                    WAIT_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_VALUE  = DATA_WIDTH'(DEFAULT_IDLE_VALUE)
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               read_strobe_n,
  input  logic [NUM_SOURCES-1:0]             source_select,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0]  source_data,
  input  logic [NUM_SOURCES*WAIT_WIDTH-1:0]  source_wait_states,
  input  logic                               external_direction,
  input  logic [DATA_WIDTH-1:0]              external_data,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               data_valid,
  output logic                               ready,
  output logic [idx_width(NUM_SOURCES)-1:0]  winner,
  output logic                               contention,
  output logic [7:0]                         contention_count,
  input  logic                               contention_clear
);

  localparam int IDX_W = idx_width(NUM_SOURCES);
  localparam logic [IDX_W-1:0] NO_SOURCE = IDX_W'(NUM_SOURCES);

  router_state_e          state_q, state_d;
  logic                   strobe_q, strobe_d;
  logic [WAIT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]       winner_q, winner_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ready_q, ready_d;
  logic                   contention_q, contention_d;
  logic [7:0]             count_q, count_d;

  logic [IDX_W-1:0]       enc_idx;
  logic                   enc_valid;
  logic                   enc_multi;
  logic [WAIT_WIDTH-1:0]  enc_wait;
  logic [DATA_WIDTH-1:0]  enc_data;
  logic [DATA_WIDTH-1:0]  winner_data;
  logic                   start_edge;
  logic                   claim_event;
  logic [7:0]             count_base;

  priority_encoder #(
    .NUM_SOURCES(NUM_SOURCES)
  ) u_priority_encoder (
    .req   (source_select),
    .idx   (enc_idx),
    .valid (enc_valid),
    .multi (enc_multi)
  );

  // Per-source muxes: the fresh claimant at E0, and the latched winner while waiting.
  always_comb begin
    enc_wait    = '0;
    enc_data    = external_direction ? external_data : IDLE_VALUE;
    winner_data = IDLE_VALUE;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (enc_valid && enc_idx == IDX_W'(i)) begin
        enc_wait = source_wait_states[i*WAIT_WIDTH +: WAIT_WIDTH];
        enc_data = source_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (winner_q == IDX_W'(i)) begin
        winner_data = source_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign start_edge  = !read_strobe_n && strobe_q && (state_q == IDLE);
  assign claim_event = start_edge && enc_multi;

  always_comb begin
    state_d      = state_q;
    strobe_d     = read_strobe_n;
    cnt_d        = cnt_q;
    winner_d     = winner_q;
    data_d       = data_q;
    valid_d      = valid_q;
    ready_d      = ready_q;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          winner_d = enc_valid ? enc_idx : NO_SOURCE;
          if (enc_valid && enc_wait != '0) begin
            cnt_d   = enc_wait - WAIT_WIDTH'(1);
            ready_d = 1'b0;
            state_d = WAIT;
          end else begin
            data_d  = enc_data;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
      end
      WAIT: begin
        if (read_strobe_n) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_WIDTH'(1);
        end else begin
          data_d  = winner_data;
          valid_d = 1'b1;
          ready_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (read_strobe_n) begin
          data_d  = IDLE_VALUE;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        data_d  = IDLE_VALUE;
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // A clear in the same cycle as an event is applied first, so the event still counts.
  always_comb begin
    count_base   = contention_clear ? 8'd0 : count_q;
    count_d      = count_base;
    contention_d = contention_q && !contention_clear;
    if (claim_event) begin
      contention_d = 1'b1;
      count_d      = (count_base == 8'hFF) ? count_base : count_base + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      strobe_q     <= 1'b1;
      cnt_q        <= '0;
      winner_q     <= NO_SOURCE;
      data_q       <= IDLE_VALUE;
      valid_q      <= 1'b0;
      ready_q      <= 1'b1;
      contention_q <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      strobe_q     <= strobe_d;
      cnt_q        <= cnt_d;
      winner_q     <= winner_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      ready_q      <= ready_d;
      contention_q <= contention_d;
      count_q      <= count_d;
    end
  end

  assign data_out         = data_q;
  assign data_valid       = valid_q;
  assign ready            = ready_q;
  assign winner           = winner_q;
  assign contention       = contention_q;
  assign contention_count = count_q;

endmodule

// File: tb/tb_data_bus_router.sv
// tb/tb_data_bus_router.sv - directed self-checking bench for data_bus_router.
module tb_data_bus_router;

  logic        clock;
  logic        reset_n;
  logic        read_strobe_n;
  logic [3:0]  source_select;
  logic [31:0] source_data;
  logic [15:0] source_wait_states;
  logic        external_direction;
  logic [7:0]  external_data;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        ready;
  logic [2:0]  winner;
  logic        contention;
  logic [7:0]  contention_count;
  logic        contention_clear;

  int n_checks;
  int n_fails;

  data_bus_router dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .read_strobe_n      (read_strobe_n),
    .source_select      (source_select),
    .source_data        (source_data),
    .source_wait_states (source_wait_states),
    .external_direction (external_direction),
    .external_data      (external_data),
    .data_out           (data_out),
    .data_valid         (data_valid),
    .ready              (ready),
    .winner             (winner),
    .contention         (contention),
    .contention_count   (contention_count),
    .contention_clear   (contention_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset_n            = 1'b0;
    read_strobe_n      = 1'b1;
    source_select      = 4'b0000;
    source_data        = 32'h0;
    source_wait_states = 16'h0;
    external_direction = 1'b0;
    external_data      = 8'h00;
    contention_clear   = 1'b0;
    step();
    step();
    check("rst_data", data_out, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_winner", winner, 3'd4);
    check("rst_cont", contention, 1'b0);
    check("rst_count", contention_count, 8'd0);
    reset_n = 1'b1;
    step();

    // Source 2, zero wait states
    source_select      = 4'b0100;
    source_data        = {8'h00, 8'hA5, 8'h00, 8'h00};
    source_wait_states = 16'h0000;
    read_strobe_n      = 1'b0;
    step();
    check("w0_data", data_out, 8'hA5);
    check("w0_valid", data_valid, 1'b1);
    check("w0_ready", ready, 1'b1);
    check("w0_winner", winner, 3'd2);
    read_strobe_n = 1'b1;
    step();
    check("w0_end_data", data_out, 8'h00);
    check("w0_end_valid", data_valid, 1'b0);

    // Source 1, three wait states
    source_select      = 4'b0010;
    source_data        = {8'h00, 8'h00, 8'h3C, 8'h00};
    source_wait_states = 16'h0030;
    read_strobe_n      = 1'b0;
    step();
    check("w3_e0_ready", ready, 1'b0);
    check("w3_e0_valid", data_valid, 1'b0);
    check("w3_e0_winner", winner, 3'd1);
    step();
    check("w3_e1_ready", ready, 1'b0);
    step();
    check("w3_e2_ready", ready, 1'b0);
    check("w3_e2_data", data_out, 8'h00);
    step();
    check("w3_e3_ready", ready, 1'b1);
    check("w3_e3_data", data_out, 8'h3C);
    check("w3_e3_valid", data_valid, 1'b1);
    source_data = 32'h0;
    step();
    check("w3_hold_data", data_out, 8'h3C);
    read_strobe_n = 1'b1;
    step();
    check("w3_end_data", data_out, 8'h00);
    check("w3_end_valid", data_valid, 1'b0);

    // Sources 0 and 3 claim: first without clear, then with clear at E0
    source_select      = 4'b1001;
    source_data        = {8'h33, 8'h00, 8'h00, 8'h11};
    source_wait_states = 16'h2000;
    read_strobe_n      = 1'b0;
    step();
    check("mc1_data", data_out, 8'h11);
    check("mc1_winner", winner, 3'd0);
    check("mc1_count", contention_count, 8'd1);
    read_strobe_n = 1'b1;
    step();
    read_strobe_n    = 1'b0;
    contention_clear = 1'b1;
    step();
    contention_clear = 1'b0;
    check("mc2_data", data_out, 8'h11);
    check("mc2_cont", contention, 1'b1);
    check("mc2_count", contention_count, 8'd1);
    read_strobe_n    = 1'b1;
    step();
    check("mc2_sticky", contention, 1'b1);
    contention_clear = 1'b1;
    step();
    contention_clear = 1'b0;
    check("clr_cont", contention, 1'b0);
    check("clr_count", contention_count, 8'd0);

    // No claims: external then none
    source_select      = 4'b0000;
    external_direction = 1'b1;
    external_data      = 8'h7E;
    read_strobe_n      = 1'b0;
    step();
    check("ext_data", data_out, 8'h7E);
    check("ext_winner", winner, 3'd4);
    check("ext_valid", data_valid, 1'b1);
    check("ext_ready", ready, 1'b1);
    read_strobe_n = 1'b1;
    step();
    external_direction = 1'b0;
    read_strobe_n      = 1'b0;
    step();
    check("none_data", data_out, 8'h00);
    check("none_winner", winner, 3'd4);
    read_strobe_n = 1'b1;
    step();

    // Abort: five wait states, strobe rises at E0+2
    source_select      = 4'b0001;
    source_data        = {8'h00, 8'h00, 8'h00, 8'h5A};
    source_wait_states = 16'h0005;
    read_strobe_n      = 1'b0;
    step();
    check("ab_e0_ready", ready, 1'b0);
    step();
    check("ab_e1_ready", ready, 1'b0);
    read_strobe_n = 1'b1;
    step();
    check("ab_ready", ready, 1'b1);
    check("ab_valid", data_valid, 1'b0);
    check("ab_data", data_out, 8'h00);
    step();
    step();
    check("ab_late_valid", data_valid, 1'b0);
    check("ab_late_data", data_out, 8'h00);

    // Reset mid-WAIT after a contention event, strobe held low through release
    source_select      = 4'b0011;
    source_data        = {8'h00, 8'h00, 8'h22, 8'h5A};
    source_wait_states = 16'h0005;
    read_strobe_n      = 1'b0;
    step();
    check("rw_cont", contention, 1'b1);
    check("rw_ready", ready, 1'b0);
    step();
    reset_n = 1'b0;
    step();
    check("rw_rst_ready", ready, 1'b1);
    check("rw_rst_valid", data_valid, 1'b0);
    check("rw_rst_cont", contention, 1'b0);
    check("rw_rst_count", contention_count, 8'd0);
    check("rw_rst_winner", winner, 3'd4);
    source_select      = 4'b0100;
    source_data        = {8'h00, 8'hA5, 8'h00, 8'h00};
    source_wait_states = 16'h0000;
    reset_n            = 1'b1;
    step();
    check("rel_data", data_out, 8'hA5);
    check("rel_valid", data_valid, 1'b1);
    read_strobe_n = 1'b1;
    step();

    // Saturation of the contention counter
    source_select      = 4'b0011;
    source_wait_states = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      read_strobe_n = 1'b0;
      step();
      read_strobe_n = 1'b1;
      step();
      if (i == 253) check("sat_254", contention_count, 8'd254);
      if (i == 254) check("sat_255", contention_count, 8'd255);
    end
    check("sat_256", contention_count, 8'd255);
    check("sat_cont", contention, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/data_bus_router.md
# data_bus_router

Parametrised, registered read-data router for the chipset's internal data bus. It replaces the fixed three-way source selection in the chipset top (peripherals, RAM, external bus) with N prioritised sources. Each source has its own programmable wait-state count, which drives a ready handshake into the READY block. The router latches the read data for the whole bus cycle and records contention whenever more than one source claims the same read.

## Interface
Parameters:
- DATA_WIDTH, 8, width of every data path.
- NUM_SOURCES, 4, number of internal claimants. Index 0 has the highest priority.
- WAIT_WIDTH, 4, width of each source's wait-state count.
- IDLE_VALUE, 0, value driven on data_out when no read is in progress.

Ports:
- clock  in  1  system clock. All logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- read_strobe_n  in  1  active-low read cycle. The integrator ties it to memory_read_n & io_read_n.
- source_select  in  NUM_SOURCES  active-high claim, one bit per source.
- source_data  in  NUM_SOURCES*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- source_wait_states  in  NUM_SOURCES*WAIT_WIDTH  static wait-state count per source.
- external_direction  in  1  1 means the external bus drives the read.
- external_data  in  DATA_WIDTH  external bus data.
- data_out  out  DATA_WIDTH  latched read data. Reset value IDLE_VALUE.
- data_valid  out  1  data_out holds captured read data. Reset value 0.
- ready  out  1  0 means wait states are being inserted. Reset value 1.
- winner  out  $clog2(NUM_SOURCES+1)  index of the captured source. NUM_SOURCES means external or none. Reset value NUM_SOURCES.
- contention  out  1  sticky flag: at least one multi-claim read has occurred. Reset value 0.
- contention_count  out  8  saturating count of multi-claim reads. Reset value 0.
- contention_clear  in  1  single-cycle pulse that clears contention and contention_count.

## Operation
- read_strobe_n is registered once into strobe_q.
- Start edge E0: the clock edge where read_strobe_n is sampled 0 and strobe_q is 1.

Arbitration at E0:
- The winner is the lowest index i with source_select[i]=1.
- If no source claims and external_direction=1, the winner is external, with wait count 0.
- If no source claims and external_direction=0, the winner is none: captured data is IDLE_VALUE, wait count 0.
- The winner and its wait count W are latched at E0. Later changes to source_select are ignored until the next E0.

FSM states and transitions:
- IDLE → HOLD at E0 when W=0. Data is captured at E0.
- IDLE → WAIT at E0 when W>0. The counter is loaded with W-1 and ready goes to 0.
- WAIT, counter>0: the counter decrements.
- WAIT, counter=0: the selected source's data is captured, data_valid goes to 1, ready goes to 1, next state HOLD.
- WAIT with read_strobe_n sampled 1 (abort): go to IDLE, ready=1, data_valid stays 0, no capture.
- HOLD: data_out is frozen. When read_strobe_n is sampled 1, go to IDLE, data_out=IDLE_VALUE, data_valid=0.

Contention:
- A contention event is two or more source_select bits set at E0.
- An event sets contention and increments contention_count, saturating at 255.
- contention_clear in the same cycle as an event: the event wins, giving contention=1 and count=1.

Reset:
- reset_n=0 at any point, including mid-WAIT or mid-HOLD, forces IDLE and all outputs to their reset values.
- strobe_q resets to 1, so a strobe that is already low when reset releases produces a start edge on the first sampled edge after release.

## Timing
- Captured data appears on data_out at edge E0+W.
- ready is 0 for exactly W cycles, from E0 until E0+W.
- data_valid rises with the capture edge. It falls on the first edge that samples read_strobe_n=1.
- Back-to-back reads need read_strobe_n high for at least one sampled edge between them.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package chipset_pkg provides:
  - the FSM state enum (IDLE, WAIT, HOLD);
  - a function that computes the index width, $clog2(NUM_SOURCES+1);
  - the default IDLE_VALUE.
- Sub-module priority_encoder, parametrised on NUM_SOURCES, produces the lowest set index, a valid bit and a multi-hit bit.
- The wait counter, capture register and contention counters live in data_bus_router.

## Test plan
- Source 2 claims, wait states 0, data 8'hA5: data_out=A5 and data_valid=1 at E0, ready stays 1, winner=2.
- Source 1 claims, wait states 3, data 8'h3C: ready is 0 for 3 cycles, data_out=3C at E0+3, then returns to 00 one edge after the strobe rises.
- Sources 0 and 3 claim (data 11 and 33) with contention_clear pulsed at E0: data_out=11, contention=1, contention_count=1. A following clear-only pulse gives count 0.
- No claims: external_direction=1 with external_data=7E gives data_out=7E immediately. external_direction=0 gives data_out=00, winner=NUM_SOURCES.
- Wait states 5, strobe rises at E0+2: FSM returns to IDLE, ready=1, data_valid never rises, no capture.
- reset_n=0 mid-WAIT gives ready=1, data_valid=0, contention 0. 256 contention events give count=255, saturated.
